// File: rtl/fpu_pipe_ctrl.sv
// Pipeline controller for the FPU: tracks E1/E2/E3/WB occupancy and one iterative divider,
// producing stage enables, ID stall, operand forwarding selects and the FP regfile write port.
module fpu_pipe_ctrl #(
    parameter int DIV_CYCLES = 24,
    parameter int CNT_W      = 5
) (
    input  logic             clock,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic             id_div,
    input  logic             id_wreg,
    input  logic [4:0]       id_fd,
    input  logic [4:0]       id_fs,
    input  logic [4:0]       id_ft,
    input  logic             id_use_fs,
    input  logic             id_use_ft,
    output logic             stall,
    output logic             e1_en,
    output logic             e2_en,
    output logic             e3_en,
    output logic             ew_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             wb_we,
    output logic [4:0]       wb_dest,
    output logic             wb_sel,
    output logic             div_start,
    output logic             div_busy,
    output logic [3:0]       pipe_valid
);

    logic             v1_q, v2_q, v3_q, vw_q;
    logic             v1_d, v2_d, v3_d, vw_d;
    logic             w1_q, w2_q, w3_q, ww_q;
    logic             w1_d, w2_d, w3_d, ww_d;
    logic [4:0]       d1_q, d2_q, d3_q, dw_q;
    logic [4:0]       d1_d, d2_d, d3_d, dw_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic [4:0]       div_dest_q, div_dest_d;

    logic             div_wb;
    logic             freeze;
    logic             accept;
    logic             accept_pipe;
    logic             accept_div;
    logic             dep_stall;
    logic             div_stall;
    logic             a_m1, a_m2, a_m3, a_mw;
    logic             b_m1, b_m2, b_m3, b_mw;

    function automatic logic src_match(
        input logic       use_src,
        input logic [4:0] src,
        input logic       v,
        input logic       w,
        input logic [4:0] d
    );
        return use_src & v & w & (d == src);
    endfunction

    // Source-vs-stage comparisons
    always_comb begin
        a_m1 = src_match(id_use_fs, id_fs, v1_q, w1_q, d1_q);
        a_m2 = src_match(id_use_fs, id_fs, v2_q, w2_q, d2_q);
        a_m3 = src_match(id_use_fs, id_fs, v3_q, w3_q, d3_q);
        a_mw = src_match(id_use_fs, id_fs, vw_q, ww_q, dw_q);
        b_m1 = src_match(id_use_ft, id_ft, v1_q, w1_q, d1_q);
        b_m2 = src_match(id_use_ft, id_ft, v2_q, w2_q, d2_q);
        b_m3 = src_match(id_use_ft, id_ft, v3_q, w3_q, d3_q);
        b_mw = src_match(id_use_ft, id_ft, vw_q, ww_q, dw_q);
    end

    // Hazard detection, stall and write-port arbitration
    always_comb begin
        div_wb    = busy_q & (count_q == '0);
        freeze    = div_wb & vw_q;
        dep_stall = a_m1 | a_m2 | b_m1 | b_m2;
        div_stall = busy_q & ((id_use_fs & (id_fs == div_dest_q))
                            | (id_use_ft & (id_ft == div_dest_q))
                            | id_div
                            | (~id_div & id_wreg & (id_fd == div_dest_q)));
        stall       = freeze | dep_stall | div_stall;
        accept      = id_valid & ~stall;
        accept_pipe = accept & ~id_div;
        accept_div  = accept & id_div;
        div_start   = accept_div;

        e1_en = ~freeze;
        e2_en = ~freeze;
        e3_en = ~freeze;
        ew_en = ~freeze;

        fwd_a = 2'd0;
        if (a_m3) begin
            fwd_a = 2'd1;
        end else if (a_mw) begin
            fwd_a = 2'd2;
        end
        fwd_b = 2'd0;
        if (b_m3) begin
            fwd_b = 2'd1;
        end else if (b_mw) begin
            fwd_b = 2'd2;
        end

        // Divider owns the write port in its final cycle; the pipeline freezes around it
        if (div_wb) begin
            wb_we   = 1'b1;
            wb_sel  = 1'b1;
            wb_dest = div_dest_q;
        end else begin
            wb_we   = vw_q & ww_q;
            wb_sel  = 1'b0;
            wb_dest = dw_q;
        end

        div_busy   = busy_q;
        pipe_valid = {vw_q, v3_q, v2_q, v1_q};
    end

    // Stage advance
    always_comb begin
        v1_d = v1_q;  w1_d = w1_q;  d1_d = d1_q;
        v2_d = v2_q;  w2_d = w2_q;  d2_d = d2_q;
        v3_d = v3_q;  w3_d = w3_q;  d3_d = d3_q;
        vw_d = vw_q;  ww_d = ww_q;  dw_d = dw_q;
        if (!freeze) begin
            v1_d = accept_pipe;
            w1_d = accept_pipe & id_wreg;
            d1_d = accept_pipe ? id_fd : 5'd0;
            v2_d = v1_q;  w2_d = w1_q;  d2_d = d1_q;
            v3_d = v2_q;  w3_d = w2_q;  d3_d = d2_q;
            vw_d = v3_q;  ww_d = w3_q;  dw_d = d3_q;
        end
    end

    // Divider occupancy: counter reaches zero in the writeback cycle
    always_comb begin
        count_d    = count_q;
        busy_d     = busy_q;
        div_dest_d = div_dest_q;
        if (accept_div) begin
            count_d    = CNT_W'(DIV_CYCLES - 1);
            busy_d     = 1'b1;
            div_dest_d = id_fd;
        end else if (busy_q) begin
            if (div_wb) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            vw_q       <= 1'b0;
            w1_q       <= 1'b0;
            w2_q       <= 1'b0;
            w3_q       <= 1'b0;
            ww_q       <= 1'b0;
            d1_q       <= 5'd0;
            d2_q       <= 5'd0;
            d3_q       <= 5'd0;
            dw_q       <= 5'd0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            div_dest_q <= 5'd0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            vw_q       <= vw_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            w3_q       <= w3_d;
            ww_q       <= ww_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            d3_q       <= d3_d;
            dw_q       <= dw_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            div_dest_q <= div_dest_d;
        end
    end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Directed self-checking bench for fpu_pipe_ctrl: hazards, forwarding, divider and freeze.
module tb_fpu_pipe_ctrl;

    logic       clock;
    logic       clrn;
    logic       id_valid;
    logic       id_div;
    logic       id_wreg;
    logic [4:0] id_fd;
    logic [4:0] id_fs;
    logic [4:0] id_ft;
    logic       id_use_fs;
    logic       id_use_ft;
    logic       stall;
    logic       e1_en;
    logic       e2_en;
    logic       e3_en;
    logic       ew_en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       wb_we;
    logic [4:0] wb_dest;
    logic       wb_sel;
    logic       div_start;
    logic       div_busy;
    logic [3:0] pipe_valid;

    int checks = 0;
    int errors = 0;

    fpu_pipe_ctrl #(.DIV_CYCLES(24), .CNT_W(5)) dut (
        .clock      (clock),
        .clrn       (clrn),
        .id_valid   (id_valid),
        .id_div     (id_div),
        .id_wreg    (id_wreg),
        .id_fd      (id_fd),
        .id_fs      (id_fs),
        .id_ft      (id_ft),
        .id_use_fs  (id_use_fs),
        .id_use_ft  (id_use_ft),
        .stall      (stall),
        .e1_en      (e1_en),
        .e2_en      (e2_en),
        .e3_en      (e3_en),
        .ew_en      (ew_en),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .wb_we      (wb_we),
        .wb_dest    (wb_dest),
        .wb_sel     (wb_sel),
        .div_start  (div_start),
        .div_busy   (div_busy),
        .pipe_valid (pipe_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic dv, input logic wr, input logic [4:0] fd,
                         input logic [4:0] fs, input logic [4:0] ft, input logic ufs,
                         input logic uft);
        id_valid  = v;
        id_div    = dv;
        id_wreg   = wr;
        id_fd     = fd;
        id_fs     = fs;
        id_ft     = ft;
        id_use_fs = ufs;
        id_use_ft = uft;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft);
        drive(1'b1, 1'b0, 1'b1, fd, fs, ft, 1'b1, 1'b1);
    endtask

    task automatic div(input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft);
        drive(1'b1, 1'b1, 1'b1, fd, fs, ft, 1'b1, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".stall"}, {7'd0, stall}, 8'd0);
        chk({tag, ".en"}, {4'd0, e1_en, e2_en, e3_en, ew_en}, 8'h0f);
        chk({tag, ".fwd"}, {4'd0, fwd_a, fwd_b}, 8'd0);
        chk({tag, ".wb"}, {1'b0, wb_we, wb_sel, wb_dest}, 8'd0);
        chk({tag, ".div"}, {6'd0, div_start, div_busy}, 8'd0);
        chk({tag, ".pv"}, {4'd0, pipe_valid}, 8'd0);
    endtask

    initial begin
        clrn = 1'b0;
        idle();
        #2;
        chk_reset_outputs("por");
        nxt();
        clrn = 1'b1;
        nxt();

        // RAW on E1/E2 producer, then E3 forward
        add(5'd1, 5'd2, 5'd3);
        chk("raw.c0.stall", {7'd0, stall}, 8'd0);
        nxt();
        add(5'd4, 5'd1, 5'd5);
        chk("raw.c1.stall", {7'd0, stall}, 8'd1);
        chk("raw.c1.pv", {4'd0, pipe_valid}, 8'b0001);
        nxt();
        chk("raw.c2.stall", {7'd0, stall}, 8'd1);
        chk("raw.c2.pv", {4'd0, pipe_valid}, 8'b0010);
        nxt();
        chk("raw.c3.stall", {7'd0, stall}, 8'd0);
        chk("raw.c3.fwd_a", {6'd0, fwd_a}, 8'd1);
        chk("raw.c3.fwd_b", {6'd0, fwd_b}, 8'd0);
        nxt();
        idle();
        chk("raw.c4.wb_f1", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd1});
        nxt();
        nxt();
        nxt();
        chk("raw.c7.wb_f4", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd4});
        nxt();
        chk("raw.c8.wb_idle", {7'd0, wb_we}, 8'd0);

        // WB forward with independent ops in between
        nxt();
        add(5'd1, 5'd2, 5'd3);
        nxt();
        add(5'd10, 5'd11, 5'd12);
        nxt();
        add(5'd13, 5'd14, 5'd15);
        nxt();
        add(5'd16, 5'd17, 5'd18);
        chk("wbf.c3.stall", {7'd0, stall}, 8'd0);
        chk("wbf.c3.pv", {4'd0, pipe_valid}, 8'b0111);
        nxt();
        add(5'd6, 5'd7, 5'd1);
        chk("wbf.c4.stall", {7'd0, stall}, 8'd0);
        chk("wbf.c4.fwd", {4'd0, fwd_a, fwd_b}, 8'b0010);
        chk("wbf.c4.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd1});
        nxt();
        idle();
        repeat (6) nxt();

        // Divider: busy window, writeback, structural and RAW stalls
        div(5'd6, 5'd20, 5'd21);
        chk("div.c0.start", {6'd0, div_start, stall}, 8'b10);
        nxt();
        div(5'd7, 5'd22, 5'd23);
        chk("div.c1.busy", {6'd0, div_busy, stall}, 8'b11);
        chk("div.c1.start", {7'd0, div_start}, 8'd0);
        nxt();
        chk("div.c2.stall", {7'd0, stall}, 8'd1);
        nxt();
        add(5'd8, 5'd6, 5'd2);
        chk("div.c3.stall", {7'd0, stall}, 8'd1);
        repeat (21) nxt();
        chk("div.c24.stall", {6'd0, div_busy, stall}, 8'b11);
        chk("div.c24.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b011, 5'd6});
        nxt();
        chk("div.c25.stall", {6'd0, div_busy, stall}, 8'b00);
        chk("div.c25.fwd_a", {6'd0, fwd_a}, 8'd0);
        chk("div.c25.wb", {7'd0, wb_we}, 8'd0);
        nxt();
        idle();
        repeat (6) nxt();

        // Freeze: divider writeback collides with a pipeline WB
        div(5'd6, 5'd20, 5'd21);
        nxt();
        idle();
        repeat (19) nxt();
        add(5'd9, 5'd1, 5'd2);
        chk("frz.c20.stall", {7'd0, stall}, 8'd0);
        nxt();
        idle();
        repeat (3) nxt();
        chk("frz.c24.stall", {7'd0, stall}, 8'd1);
        chk("frz.c24.en", {4'd0, e1_en, e2_en, e3_en, ew_en}, 8'h00);
        chk("frz.c24.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b011, 5'd6});
        chk("frz.c24.pv", {4'd0, pipe_valid}, 8'b1000);
        nxt();
        chk("frz.c25.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd9});
        chk("frz.c25.en", {4'd0, e1_en, e2_en, e3_en, ew_en}, 8'h0f);
        chk("frz.c25.busy", {6'd0, div_busy, stall}, 8'b00);
        nxt();
        chk("frz.c26.wb", {7'd0, wb_we}, 8'd0);
        repeat (3) nxt();

        // WAW against the in-flight divide
        div(5'd3, 5'd20, 5'd21);
        nxt();
        add(5'd3, 5'd1, 5'd2);
        chk("waw.c1.stall", {7'd0, stall}, 8'd1);
        repeat (23) nxt();
        chk("waw.c24.stall", {7'd0, stall}, 8'd1);
        chk("waw.c24.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b011, 5'd3});
        nxt();
        chk("waw.c25.stall", {6'd0, div_busy, stall}, 8'b00);
        nxt();
        idle();
        repeat (3) nxt();
        chk("waw.c29.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd3});
        repeat (3) nxt();

        // Reset mid-operation abandons the divide and the pipeline
        div(5'd5, 5'd20, 5'd21);
        nxt();
        add(5'd12, 5'd13, 5'd14);
        nxt();
        idle();
        chk("rst.pre.pv", {4'd0, pipe_valid}, 8'b0001);
        clrn = 1'b0;
        #1;
        chk_reset_outputs("rst");
        nxt();
        clrn = 1'b1;
        for (int i = 0; i < 26; i++) begin
            chk("rst.no_wb", {6'd0, wb_we, div_busy}, 8'd0);
            nxt();
        end
        add(5'd1, 5'd2, 5'd3);
        chk("rst.c0.stall", {7'd0, stall}, 8'd0);
        nxt();
        idle();
        repeat (3) nxt();
        chk("rst.c4.wb", {1'b0, wb_we, wb_sel, wb_dest}, {3'b010, 5'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
